// File: rtl/uart_tx_responder_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets, STATUS bit positions, TX FSM encoding and the divisor clamp.
package uart_tx_responder_pkg;

   localparam int unsigned BAUD_W = 16;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;

   localparam int unsigned STAT_FULL  = 0;
   localparam int unsigned STAT_EMPTY = 1;
   localparam int unsigned STAT_BUSY  = 2;

   localparam logic [BAUD_W-1:0] BAUD_MIN = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   // Divisors below 2 would make a bit shorter than the counter can time.
   function automatic logic [BAUD_W-1:0] eff_div(input logic [BAUD_W-1:0] d);
      return (d < BAUD_MIN) ? BAUD_MIN : d;
   endfunction

endpackage

// File: rtl/uart_tx_responder_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the oldest entry.
// Pointers carry one extra wrap bit so full and empty stay distinguishable.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;

   // A push into a full FIFO is only honoured when a pop frees the slot the same cycle.
   assign do_push_c = push && (!full || pop);
   assign do_pop_c  = pop && !empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/BAUD registers, TX FIFO,
// and a START/DATA/STOP serialiser that chains frames without idle gaps.
module uart_tx_responder
   import uart_tx_responder_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned BAUD_DIV_RESET = 868
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        enable,
   input  logic        mem_valid,
   input  logic [3:0]  mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        tx
);

   logic [1:0]        sel_c;
   logic              is_wr_c;
   logic              data_wr_c;
   logic              pending_c;
   logic              accept_c;
   logic              push_c;
   logic              pop_c;
   logic [31:0]       rdata_c;

   logic [7:0]        fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [BAUD_W-1:0] baud_div;

   tx_state_e         state_q;
   tx_state_e         state_d;
   logic [7:0]        shift_q;
   logic [7:0]        shift_d;
   logic [BAUD_W-1:0] cnt_q;
   logic [BAUD_W-1:0] cnt_d;
   logic [BAUD_W-1:0] div_q;
   logic [BAUD_W-1:0] div_d;
   logic [2:0]        bit_q;
   logic [2:0]        bit_d;
   logic              tx_d;
   logic              last_c;
   logic              load_c;

   logic              unused_bits;
   assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:BAUD_W]};

   // Bus decode: a DATA write to a full FIFO stalls unless the serialiser pops this cycle.
   assign sel_c     = mem_addr[3:2];
   assign is_wr_c   = |mem_wstrb;
   assign data_wr_c = is_wr_c && (sel_c == REG_DATA);
   assign pending_c = mem_valid && enable && !mem_ready;
   assign accept_c  = pending_c && !(data_wr_c && fifo_full && !pop_c);
   assign push_c    = accept_c && data_wr_c;

   always_comb begin
      rdata_c = '0;
      case (sel_c)
         REG_STATUS: begin
            rdata_c[STAT_FULL]  = fifo_full;
            rdata_c[STAT_EMPTY] = fifo_empty;
            rdata_c[STAT_BUSY]  = (state_q != ST_IDLE);
         end
         REG_BAUD: rdata_c[BAUD_W-1:0] = baud_div;
         default:  rdata_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         baud_div  <= BAUD_W'(BAUD_DIV_RESET);
      end else begin
         mem_ready <= accept_c;
         mem_rdata <= (accept_c && !is_wr_c) ? rdata_c : '0;
         if (accept_c && is_wr_c && (sel_c == REG_BAUD)) baud_div <= mem_wdata[BAUD_W-1:0];
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_c),
      .pop    (pop_c),
      .din    (mem_wdata[7:0]),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         div_q   <= BAUD_MIN;
         bit_q   <= '0;
         tx      <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx      <= tx_d;
      end
   end

   assign last_c = (cnt_q == div_q - 16'd1);

   // Serialiser; the divisor is latched per frame so BAUD writes never disturb a frame in flight.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      bit_d   = bit_q;
      load_c  = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load_c = 1'b1;
         end
         ST_START: begin
            if (last_c) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (last_c) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = ST_STOP;
               end else begin
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (last_c) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (!fifo_empty) load_c = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (load_c) begin
         shift_d = fifo_dout;
         div_d   = eff_div(baud_div);
         cnt_d   = '0;
         state_d = ST_START;
      end
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   assign pop_c = load_c;

endmodule

// File: tb/tb_uart_tx_responder.sv
// Bench for uart_tx_responder: frame-level reference model compared every cycle,
// plus directed register accesses and literal tx bit patterns.
module tb_uart_tx_responder;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        mem_valid = 1'b0;
   logic [3:0]  mem_addr = 4'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic [3:0]  mem_wstrb = 4'h0;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        tx;

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   always #5 clk = ~clk;

   uart_tx_responder #(
      .FIFO_DEPTH     (4),
      .BAUD_DIV_RESET (868)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .tx        (tx)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: byte queue, one frame descriptor, registered bus response.
   logic [7:0]  m_q[$];
   logic [15:0] m_baud = 16'd868;
   bit          m_ready = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   bit          m_act = 1'b0;
   int          m_el = 0;
   int          m_div = 2;
   logic [9:0]  m_frame = 10'h3FF;
   int          m_sz;
   bit          m_pop, m_pend, m_wr, m_acc;
   logic [1:0]  m_sel;
   logic [31:0] m_rd;
   logic [7:0]  m_byte;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_q.delete();
         m_baud  = 16'd868;
         m_ready = 1'b0;
         m_rdata = 32'h0;
         m_act   = 1'b0;
         m_el    = 0;
      end else begin
         m_sz   = m_q.size();
         m_pop  = (m_sz > 0) && (!m_act || (m_el == 10 * m_div - 1));
         m_pend = mem_valid && enable && !m_ready;
         m_wr   = (mem_wstrb != 4'h0);
         m_sel  = mem_addr[3:2];
         m_acc  = m_pend && !(m_wr && (m_sel == 2'd0) && (m_sz == DEPTH) && !m_pop);
         m_rd   = 32'h0;
         if (m_acc && !m_wr) begin
            if (m_sel == 2'd1) m_rd = {29'd0, m_act, (m_sz == 0), (m_sz == DEPTH)};
            else if (m_sel == 2'd2) m_rd = {16'd0, m_baud};
         end
         if (m_act) begin
            m_el++;
            if (m_el == 10 * m_div) m_act = 1'b0;
         end
         if (m_pop) begin
            m_byte  = m_q.pop_front();
            m_frame = {1'b1, m_byte, 1'b0};
            m_div   = (m_baud < 16'd2) ? 2 : int'(m_baud);
            m_el    = 0;
            m_act   = 1'b1;
         end
         if (m_acc && m_wr && (m_sel == 2'd0)) m_q.push_back(mem_wdata[7:0]);
         if (m_acc && m_wr && (m_sel == 2'd2)) m_baud = mem_wdata[15:0];
         m_ready = m_acc;
         m_rdata = m_rd;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("cyc_ready", 32'(mem_ready), 32'(m_ready));
         chk("cyc_rdata", mem_rdata, m_rdata);
         chk("cyc_tx", 32'(tx), 32'(m_act ? m_frame[m_el / m_div] : 1'b1));
      end
   end

   task automatic bus(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output int cyc);
      @(negedge clk);
      enable    = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mem_ready && cyc < 2000);
      chk("bus_ready", 32'(mem_ready), 32'd1);
      rd        = mem_rdata;
      mem_valid = 1'b0;
      enable    = 1'b0;
      mem_wstrb = 4'h0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] r;
      int c;
      bus(a, d, 4'hF, r, c);
   endtask

   task automatic rdc(input string nm, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] r;
      int c;
      bus(a, 32'h0, 4'h0, r, c);
      chk(nm, r, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int c;
      logic [9:0] pat;
      logic [9:0] p2;
      logic [9:0] p3;
      int n;

      repeat (3) @(negedge clk);
      resetn  = 1'b1;
      run_cmp = 1'b1;
      rdc("rst_status", 4'h4, 32'h2);
      rdc("rst_baud", 4'h8, 32'd868);

      // Reset in the middle of a slow frame.
      wr(4'h0, 32'h3C);
      repeat (100) @(negedge clk);
      chk("midframe_tx", 32'(tx), 32'd0);
      #2 resetn = 1'b0;
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ready", 32'(mem_ready), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      rdc("rst2_status", 4'h4, 32'h2);
      rdc("rst2_baud", 4'h8, 32'd868);

      // Single byte at 4 cycles per bit.
      wr(4'h8, 32'd4);
      wr(4'h0, 32'hA5);
      chk("lat_tx_high", 32'(tx), 32'd1);
      pat = 10'h34A;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("a5_bit", 32'(tx), 32'(pat[i / 4]));
      end
      @(negedge clk);
      chk("a5_idle", 32'(tx), 32'd1);

      // FIFO fills behind a running frame; the fifth write stalls.
      wr(4'h0, 32'hA5);
      rdc("busy_status", 4'h4, 32'h6);
      for (int b = 1; b <= 5; b++) begin
         bus(4'h0, 32'(b), 4'hF, r, c);
         if (b < 5) chk("nostall_cyc", 32'(c), 32'd1);
         else chk("stall_seen", 32'(c > 5), 32'd1);
      end
      rdc("full_status", 4'h4, 32'h5);
      repeat (230) @(negedge clk);
      rdc("drain_status", 4'h4, 32'h2);

      // Divisor clamp and BAUD change during a frame.
      p2 = 10'h2B4;
      p3 = 10'h386;
      fork
         begin
            wr(4'h8, 32'd0);
            wr(4'h0, 32'h5A);
            wr(4'h0, 32'hC3);
            wr(4'h8, 32'd8);
         end
         begin
            n = 0;
            @(negedge clk);
            while (tx !== 1'b0 && n < 200) begin
               @(negedge clk);
               n++;
            end
            chk("clamp_start_seen", 32'(tx), 32'd0);
            for (int i = 0; i < 100; i++) begin
               if (i < 20) chk("clamp_bit", 32'(tx), 32'(p2[i / 2]));
               else chk("slow_bit", 32'(tx), 32'(p3[(i - 20) / 8]));
               @(negedge clk);
            end
            chk("clamp_idle", 32'(tx), 32'd1);
         end
      join

      // Bus rules.
      @(negedge clk);
      mem_valid = 1'b1;
      enable    = 1'b0;
      mem_addr  = 4'h0;
      mem_wdata = 32'h77;
      mem_wstrb = 4'hF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("noenable_ready", 32'(mem_ready), 32'd0);
      end
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      rdc("noenable_status", 4'h4, 32'h2);
      rdc("rsvd_read", 4'hC, 32'h0);
      rdc("data_read", 4'h0, 32'h0);
      wr(4'hC, 32'hFFFF_FFFF);
      rdc("baud_after_rsvd", 4'h8, 32'd8);
      wr(4'h8, 32'h1234_0003);
      rdc("baud_upper", 4'h8, 32'h3);

      // Pointer wrap-around through the 4-deep FIFO.
      wr(4'h8, 32'd2);
      for (int b = 8'h10; b <= 8'h19; b++) wr(4'h0, 32'(b));
      repeat (260) @(negedge clk);
      rdc("wrap_status", 4'h4, 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_responder.md
Name: uart_tx_responder

Overview:
- Memory-mapped UART transmitter peripheral on the CPU memory bus; it is the responder behind one address-decoder enable line.
- The CPU writes bytes into a small TX FIFO and polls status; the block serialises bytes 8N1, LSB first, on tx.
- A 16-byte register window is selected by enable; address[3:2] picks the register.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, at least 2.
- BAUD_DIV_RESET, 868, reset value of the bit-period divisor in clk cycles (100 MHz / 115200).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- enable  in  1  device select from the address decoder
- mem_valid  in  1  bus request; held by the initiator until mem_ready
- mem_addr  in  4  byte offset in the window; bits [3:2] used
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read, any nonzero = write
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data; valid only while mem_ready = 1, else 0
- tx  out  1  serial output; idles high

Behaviour:
- Reset (async, resetn = 0):
  - mem_ready = 0, mem_rdata = 0, tx = 1.
  - FIFO empty, FSM in IDLE, baud_div = BAUD_DIV_RESET.
  - Reset mid-frame aborts the frame immediately and drives tx high; FIFO contents are lost.
- Registers (offset via address[3:2]):
  - 0x0 DATA: write pushes mem_wdata[7:0]; reads return 0.
  - 0x4 STATUS (read-only): bit0 = fifo_full, bit1 = fifo_empty, bit2 = busy (FSM not IDLE), other bits 0.
  - 0x8 BAUD: read/write, bits [15:0]; upper bits ignored on write and read as 0.
  - 0xC: reads 0; writes ignored.
- Bus handshake:
  - A request is pending when mem_valid & enable & !mem_ready.
  - mem_ready is registered and asserts the cycle after acceptance, for exactly one cycle.
  - Back-to-back requests therefore complete at most every 2 cycles.
  - Write to DATA while the FIFO is full: the request is not accepted and mem_ready is withheld until a pop frees an entry. The push happens at acceptance. No data is dropped, and there is no overflow flag.
  - A push and a pop in the same cycle on a full FIFO are legal: the pop frees the slot, so the push is accepted that cycle.
  - mem_wstrb is treated as all-or-nothing: any nonzero value is a full write.
  - mem_valid without enable is ignored entirely; mem_ready stays 0.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is not empty, pop into a shift register, latch eff_div = max(baud_div, 2), clear the counter, and go to START. tx = 1 while in IDLE.
  - START: tx = 0 for eff_div cycles, then DATA with bit index 0.
  - DATA: tx = shift[0] for eff_div cycles per bit, shifting right; after bit 7, go to STOP.
  - STOP: tx = 1 for eff_div cycles, then IDLE.
  - The next byte's START can begin the cycle after STOP ends, so there is no extra idle bit between frames.
- Latency: with the FIFO empty and FSM in IDLE, tx falls on the 2nd clk edge after the mem_ready cycle (push, then pop).
- BAUD writes take effect at the next frame start, never mid-frame. BAUD values 0 and 1 behave as 2.
- Counters: bit counter 3 bits, period counter 16 bits. FIFO pointers are log2(FIFO_DEPTH)+1 bits so full and empty can be distinguished after wrap-around.

Decomposition:
- Shared package holds:
  - register offset constants: REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_BAUD = 2'd2;
  - STATUS bit indices;
  - FSM state encoding (2-bit).
- One sub-module: sync_fifo. Parameters are width 8 and depth; ports are push, pop, din, dout, full, empty. It gives first-word-fall-through reads.

Test Plan:
- Reset: assert resetn = 0 mid-frame -> tx = 1 immediately, STATUS reads 0x2, BAUD reads 868.
- Single byte: write BAUD = 4, write DATA = 0xA5 -> tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; total frame 40 cycles; STATUS bit2 = 1 during the frame.
- FIFO full stall: BAUD = 4, write 5 bytes 0x01..0x05 back-to-back with FIFO_DEPTH = 4 -> the 5th write's mem_ready is delayed until the first pop. All 5 bytes appear on tx in order with no gaps, and STATUS bit0 = 1 while full.
- Baud clamp and mid-frame change: BAUD = 0 -> 2-cycle bits. Write BAUD = 8 during a frame -> the current frame stays at 2 cycles per bit and the next frame uses 8.
- Bus rules: mem_valid with enable = 0 -> no mem_ready. Read 0xC -> rdata 0. Read DATA -> 0. mem_rdata is 0 in every cycle where mem_ready = 0.
- Wrap-around: push and drain 10 bytes (0x10..0x19) through the 4-deep FIFO -> output order is preserved, and STATUS reads 0x2 at the end.
